// File: rtl/wt_mem_req_arbiter_if.sv
// Requester-side and memory-side request buses of the write-through memory
// request arbiter. The DUT uses the slave view; the requesters and NoC adapter use the master view.
interface wt_mem_req_arbiter_if #(
  parameter int unsigned AddrWidth            = 64,
  parameter int unsigned DataWidth            = 64,
  parameter int unsigned TidWidth             = 2,
  parameter int unsigned MaxOutstandingStores = 7,
  parameter int unsigned CntWidth             = $clog2(MaxOutstandingStores + 1)
);
  logic [2:0]             req_valid_i;
  logic [2:0]             req_ready_o;
  logic [3*AddrWidth-1:0] req_addr_i;
  logic [2:0]             req_nc_i;
  logic [3*TidWidth-1:0]  req_tid_i;
  logic [DataWidth-1:0]   store_wdata_i;
  logic [DataWidth/8-1:0] store_be_i;
  logic                   mem_req_valid_o;
  logic                   mem_req_ready_i;
  logic [1:0]             mem_req_src_o;
  logic [AddrWidth-1:0]   mem_req_addr_o;
  logic [DataWidth-1:0]   mem_req_wdata_o;
  logic [DataWidth/8-1:0] mem_req_be_o;
  logic [TidWidth-1:0]    mem_req_tid_o;
  logic                   mem_req_nc_o;
  logic                   store_ack_i;
  logic                   fence_req_i;
  logic                   fence_done_o;
  logic [CntWidth-1:0]    stores_pending_o;
  logic                   err_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_nc_i, req_tid_i, store_wdata_i, store_be_i,
           mem_req_ready_i, store_ack_i, fence_req_i,
    output req_ready_o, mem_req_valid_o, mem_req_src_o, mem_req_addr_o, mem_req_wdata_o,
           mem_req_be_o, mem_req_tid_o, mem_req_nc_o, fence_done_o, stores_pending_o, err_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_nc_i, req_tid_i, store_wdata_i, store_be_i,
           mem_req_ready_i, store_ack_i, fence_req_i,
    input  req_ready_o, mem_req_valid_o, mem_req_src_o, mem_req_addr_o, mem_req_wdata_o,
           mem_req_be_o, mem_req_tid_o, mem_req_nc_o, fence_done_o, stores_pending_o, err_o
  );
endinterface

// File: rtl/wt_mem_req_arbiter.sv
// Round-robin arbiter sharing the write-through cache memory request port between
// ifetch, load and store requesters, with store tracking, nc-load ordering and fence drain.
module wt_mem_req_arbiter #(
  parameter int unsigned AddrWidth            = 64,
  parameter int unsigned DataWidth            = 64,
  parameter int unsigned TidWidth             = 2,
  parameter int unsigned MaxOutstandingStores = 7,
  parameter int unsigned CntWidth             = $clog2(MaxOutstandingStores + 1)
) (
  input logic               clk_i,
  input logic               rst_ni,
  wt_mem_req_arbiter_if.slave bus
);
  localparam int unsigned BeWidth = DataWidth / 8;

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_e;

  state_e               state_q;
  logic                 fence_done_q;
  logic                 held_valid_q;
  logic [1:0]           held_src_q;
  logic [AddrWidth-1:0] held_addr_q;
  logic [DataWidth-1:0] held_wdata_q;
  logic [BeWidth-1:0]   held_be_q;
  logic [TidWidth-1:0]  held_tid_q;
  logic                 held_nc_q;
  logic [1:0]           rr_q;
  logic [CntWidth-1:0]  cnt_q;
  logic                 err_q;

  logic                 free;
  logic                 held_is_store;
  logic                 store_full;
  logic [2:0]           elig;
  logic [2:0]           req_ready;
  logic                 grant_any;
  logic [1:0]           grant_port;
  logic                 store_acc;
  logic [CntWidth-1:0]  cnt_d;
  logic                 underflow;
  logic                 next_valid;

  function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [1:0] off);
    logic [2:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= 3'd3) sum = sum - 3'd3;
    return sum[1:0];
  endfunction

  assign free          = !held_valid_q || bus.mem_req_ready_i;
  assign held_is_store = held_valid_q && (held_src_q == 2'd2);
  assign store_full    = (cnt_q == CntWidth'(MaxOutstandingStores));

  always_comb begin
    elig = bus.req_valid_i;
    if (store_full) elig[2] = 1'b0;
    // nc loads must not overtake any store still in flight or held
    if (bus.req_nc_i[1] && ((cnt_q != '0) || held_is_store)) elig[1] = 1'b0;
    if ((state_q != IDLE) || !rst_ni) elig = '0;
  end

  always_comb begin
    req_ready  = '0;
    grant_any  = 1'b0;
    grant_port = '0;
    if (free) begin
      for (int unsigned k = 0; k < 3; k++) begin
        if (!grant_any && elig[rr_idx(rr_q, 2'(k))]) begin
          grant_any  = 1'b1;
          grant_port = rr_idx(rr_q, 2'(k));
        end
      end
    end
    if (grant_any) req_ready[grant_port] = 1'b1;
  end

  assign store_acc  = grant_any && (grant_port == 2'd2);
  assign next_valid = grant_any || (held_valid_q && !free);

  always_comb begin
    cnt_d     = cnt_q;
    underflow = 1'b0;
    if (store_acc && !bus.store_ack_i) begin
      cnt_d = cnt_q + CntWidth'(1);
    end else if (!store_acc && bus.store_ack_i) begin
      if (cnt_q == '0) underflow = 1'b1;
      else             cnt_d = cnt_q - CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      held_valid_q <= 1'b0;
      held_src_q   <= '0;
      held_addr_q  <= '0;
      held_wdata_q <= '0;
      held_be_q    <= '0;
      held_tid_q   <= '0;
      held_nc_q    <= 1'b0;
      rr_q         <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      held_valid_q <= next_valid;
      if (grant_any) begin
        held_src_q   <= grant_port;
        held_addr_q  <= bus.req_addr_i[grant_port*AddrWidth +: AddrWidth];
        held_tid_q   <= bus.req_tid_i[grant_port*TidWidth +: TidWidth];
        held_nc_q    <= bus.req_nc_i[grant_port];
        held_wdata_q <= (grant_port == 2'd2) ? bus.store_wdata_i : '0;
        held_be_q    <= (grant_port == 2'd2) ? bus.store_be_i : '0;
        rr_q         <= rr_idx(grant_port, 2'd1);
      end
      cnt_q <= cnt_d;
      if (underflow) err_q <= 1'b1;
    end
  end

  // Drain completion looks at next-state values so a same-cycle ack counts
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      fence_done_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          fence_done_q <= 1'b0;
          if (bus.fence_req_i) state_q <= DRAIN;
        end
        DRAIN: begin
          if (!next_valid && (cnt_d == '0)) begin
            state_q      <= DONE;
            fence_done_q <= 1'b1;
          end
        end
        DONE: begin
          state_q      <= IDLE;
          fence_done_q <= 1'b0;
        end
        default: begin
          state_q      <= IDLE;
          fence_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready_o      = req_ready;
  assign bus.mem_req_valid_o  = held_valid_q;
  assign bus.mem_req_src_o    = held_src_q;
  assign bus.mem_req_addr_o   = held_addr_q;
  assign bus.mem_req_wdata_o  = held_wdata_q;
  assign bus.mem_req_be_o     = held_be_q;
  assign bus.mem_req_tid_o    = held_tid_q;
  assign bus.mem_req_nc_o     = held_nc_q;
  assign bus.fence_done_o     = fence_done_q;
  assign bus.stores_pending_o = cnt_q;
  assign bus.err_o            = err_q;
endmodule

// File: tb/tb_wt_mem_req_arbiter.sv
// Self-checking bench for wt_mem_req_arbiter: directed scenarios plus random traffic,
// all checked against a cycle-level behavioural model of the arbitration rules.
module tb_wt_mem_req_arbiter;
  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int TW  = 2;
  localparam int MAX = 7;
  localparam int CW  = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wt_mem_req_arbiter_if #(.AddrWidth(AW), .DataWidth(DW), .TidWidth(TW),
                          .MaxOutstandingStores(MAX), .CntWidth(CW)) bus ();

  wt_mem_req_arbiter #(.AddrWidth(AW), .DataWidth(DW), .TidWidth(TW),
                       .MaxOutstandingStores(MAX), .CntWidth(CW)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // model state
  bit            m_valid;
  int            m_src, m_rr, m_cnt, m_phase;  // phase: 0 idle, 1 draining, 2 done
  bit            m_err;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [7:0]    m_be;
  logic [TW-1:0] m_tid;
  logic          m_nc;
  logic [2:0]    e_ready;
  int            e_acc;
  bit            e_free;

  task automatic model_reset();
    m_valid = 0; m_src = 0; m_rr = 0; m_cnt = 0; m_phase = 0; m_err = 0;
    m_addr = '0; m_wdata = '0; m_be = '0; m_tid = '0; m_nc = 1'b0;
  endtask

  task automatic model_eval();
    e_ready = '0;
    e_acc   = -1;
    e_free  = !m_valid || bus.mem_req_ready_i;
    if (rst_n && e_free && m_phase == 0) begin
      for (int k = 0; k < 3; k++) begin
        int p;
        bit ok;
        p  = (m_rr + k) % 3;
        ok = bus.req_valid_i[p];
        if (p == 2 && m_cnt == MAX) ok = 0;
        if (p == 1 && bus.req_nc_i[1] && (m_cnt != 0 || (m_valid && m_src == 2))) ok = 0;
        if (ok && e_acc < 0) begin
          e_acc      = p;
          e_ready[p] = 1'b1;
        end
      end
    end
  endtask

  task automatic model_commit();
    int n;
    n = m_cnt + ((e_acc == 2) ? 1 : 0) - (bus.store_ack_i ? 1 : 0);
    if (bus.store_ack_i && m_cnt == 0 && e_acc != 2) begin
      m_err = 1;
      n     = 0;
    end
    if (e_acc >= 0) begin
      m_valid = 1;
      m_src   = e_acc;
      m_addr  = bus.req_addr_i[e_acc*AW +: AW];
      m_tid   = bus.req_tid_i[e_acc*TW +: TW];
      m_nc    = bus.req_nc_i[e_acc];
      m_wdata = (e_acc == 2) ? bus.store_wdata_i : '0;
      m_be    = (e_acc == 2) ? bus.store_be_i : '0;
      m_rr    = (e_acc + 1) % 3;
    end else if (e_free) begin
      m_valid = 0;
    end
    case (m_phase)
      0:       if (bus.fence_req_i) m_phase = 1;
      1:       if (!m_valid && n == 0) m_phase = 2;
      default: m_phase = 0;
    endcase
    m_cnt = n;
  endtask

  task automatic drive_idle();
    bus.req_valid_i = '0; bus.req_addr_i = '0; bus.req_nc_i = '0; bus.req_tid_i = '0;
    bus.store_wdata_i = '0; bus.store_be_i = '0; bus.mem_req_ready_i = 1'b0;
    bus.store_ack_i = 1'b0; bus.fence_req_i = 1'b0;
  endtask

  task automatic rand_fields();
    for (int p = 0; p < 3; p++) begin
      bus.req_addr_i[p*AW +: AW] = {$urandom, $urandom};
      bus.req_tid_i[p*TW +: TW]  = TW'($urandom);
    end
    bus.store_wdata_i = {$urandom, $urandom};
    bus.store_be_i    = 8'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    bus.mem_req_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      bus.req_valid_i = 3'($urandom_range(1, 7));
      rand_fields();
      #1; model_eval();
      total++;
      if (bus.req_ready_o !== e_ready) begin
        bad++; $display("FAIL reset_pre_ready: got %b want %b", bus.req_ready_o, e_ready);
      end
      tick();
    end
    rst_n = 1'b0;
    bus.req_valid_i = 3'b111;
    #1;
    total++;
    if (bus.req_ready_o !== 3'b000) begin
      bad++; $display("FAIL reset_ready: got %b want 000", bus.req_ready_o);
    end
    total++;
    if ({bus.mem_req_valid_o, bus.mem_req_src_o, bus.mem_req_addr_o, bus.mem_req_wdata_o,
         bus.mem_req_be_o, bus.mem_req_tid_o, bus.mem_req_nc_o, bus.fence_done_o,
         bus.stores_pending_o, bus.err_o} !== '0) begin
      bad++; $display("FAIL reset_outputs: valid=%b src=%0d addr=%h cnt=%0d err=%b want all zero",
                      bus.mem_req_valid_o, bus.mem_req_src_o, bus.mem_req_addr_o,
                      bus.stores_pending_o, bus.err_o);
    end
    do_reset();
  endtask

  task automatic test_round_robin();
    int exp_src[6] = '{0, 1, 2, 0, 1, 2};
    do_reset();
    bus.req_valid_i = 3'b111;
    bus.mem_req_ready_i = 1'b1;
    for (int c = 0; c < 7; c++) begin
      rand_fields();
      #1; model_eval();
      total++;
      if (bus.req_ready_o !== e_ready) begin
        bad++; $display("FAIL rr_ready c%0d: got %b want %b", c, bus.req_ready_o, e_ready);
      end
      if (c == 0) begin
        total++;
        if (bus.mem_req_valid_o !== 1'b0) begin
          bad++; $display("FAIL rr_latency: valid=%b want 0", bus.mem_req_valid_o);
        end
      end else begin
        total++;
        if (bus.mem_req_valid_o !== 1'b1 || bus.mem_req_src_o !== 2'(exp_src[c-1])) begin
          bad++; $display("FAIL rr_src c%0d: valid=%b src=%0d want 1/%0d",
                          c, bus.mem_req_valid_o, bus.mem_req_src_o, exp_src[c-1]);
        end
      end
      tick();
    end
  endtask

  task automatic test_store_limit();
    int n = 0;
    do_reset();
    bus.req_valid_i = 3'b100;
    bus.mem_req_ready_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      rand_fields();
      #1; model_eval();
      total++;
      if (bus.req_ready_o !== e_ready) begin
        bad++; $display("FAIL limit_ready c%0d: got %b want %b", c, bus.req_ready_o, e_ready);
      end
      if (bus.req_ready_o[2]) n++;
      tick();
    end
    #1;
    total++;
    if (n != 7 || bus.stores_pending_o !== 3'd7 || bus.req_ready_o[2] !== 1'b0) begin
      bad++; $display("FAIL limit_full: accepted=%0d cnt=%0d ready2=%b want 7/7/0",
                      n, bus.stores_pending_o, bus.req_ready_o[2]);
    end
    bus.store_ack_i = 1'b1;
    model_eval();
    tick();
    bus.store_ack_i = 1'b0;
    n = 0;
    for (int c = 0; c < 4; c++) begin
      #1; model_eval();
      if (bus.req_ready_o[2]) n++;
      tick();
    end
    total++;
    if (n != 1 || bus.stores_pending_o !== 3'd7) begin
      bad++; $display("FAIL limit_refill: accepted=%0d cnt=%0d want 1/7", n, bus.stores_pending_o);
    end
  endtask

  task automatic test_nc_load();
    do_reset();
    bus.mem_req_ready_i = 1'b1;
    bus.req_valid_i = 3'b100;
    for (int c = 0; c < 3; c++) begin
      rand_fields(); #1; model_eval(); tick();
    end
    bus.req_valid_i = 3'b011;
    bus.req_nc_i = 3'b010;
    #1; model_eval();
    total++;
    if (bus.req_ready_o !== 3'b001 || e_ready !== 3'b001) begin
      bad++; $display("FAIL nc_ifetch_first: got %b want 001", bus.req_ready_o);
    end
    tick();
    bus.req_valid_i = 3'b010;
    bus.store_ack_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1; model_eval();
      total++;
      if (bus.req_ready_o !== 3'b000) begin
        bad++; $display("FAIL nc_stall c%0d: got %b want 000", c, bus.req_ready_o);
      end
      tick();
    end
    bus.store_ack_i = 1'b0;
    #1; model_eval();
    total++;
    if (bus.req_ready_o !== 3'b010 || bus.stores_pending_o !== 3'd0) begin
      bad++; $display("FAIL nc_release: ready=%b cnt=%0d want 010/0", bus.req_ready_o, bus.stores_pending_o);
    end
    tick();
    total++;
    if (bus.mem_req_valid_o !== 1'b1 || bus.mem_req_src_o !== 2'd1 || bus.mem_req_nc_o !== 1'b1) begin
      bad++; $display("FAIL nc_held: valid=%b src=%0d nc=%b want 1/1/1",
                      bus.mem_req_valid_o, bus.mem_req_src_o, bus.mem_req_nc_o);
    end
    bus.req_nc_i = '0;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] wd;
    do_reset();
    wd = {$urandom, $urandom};
    bus.mem_req_ready_i = 1'b0;
    bus.req_valid_i = 3'b100;
    bus.req_addr_i[2*AW +: AW] = 64'h0000_0000_8000_0010;
    bus.req_tid_i[2*TW +: TW] = 2'd1;
    bus.store_wdata_i = wd;
    bus.store_be_i = 8'hFF;
    #1; model_eval();
    total++;
    if (bus.req_ready_o !== 3'b100) begin
      bad++; $display("FAIL bp_accept: got %b want 100", bus.req_ready_o);
    end
    tick();
    bus.req_valid_i = 3'b111;
    for (int c = 0; c < 5; c++) begin
      rand_fields();
      #1; model_eval();
      total++;
      if (bus.req_ready_o !== 3'b000) begin
        bad++; $display("FAIL bp_ready c%0d: got %b want 000", c, bus.req_ready_o);
      end
      total++;
      if (bus.mem_req_valid_o !== 1'b1 || bus.mem_req_src_o !== 2'd2 ||
          bus.mem_req_addr_o !== 64'h0000_0000_8000_0010 || bus.mem_req_be_o !== 8'hFF ||
          bus.mem_req_wdata_o !== wd || bus.mem_req_tid_o !== 2'd1) begin
        bad++; $display("FAIL bp_hold c%0d: valid=%b src=%0d addr=%h be=%h wdata=%h tid=%0d want 1/2/80000010/ff/%h/1",
                        c, bus.mem_req_valid_o, bus.mem_req_src_o, bus.mem_req_addr_o,
                        bus.mem_req_be_o, bus.mem_req_wdata_o, bus.mem_req_tid_o, wd);
      end
      tick();
    end
    bus.mem_req_ready_i = 1'b1;
    #1; model_eval();
    total++;
    if (bus.req_ready_o !== e_ready || e_ready !== 3'b001) begin
      bad++; $display("FAIL bp_release: got %b want %b", bus.req_ready_o, e_ready);
    end
    tick();
  endtask

  task automatic test_fence();
    do_reset();
    bus.mem_req_ready_i = 1'b1;
    bus.req_valid_i = 3'b100;
    for (int c = 0; c < 2; c++) begin
      rand_fields(); #1; model_eval(); tick();
    end
    bus.req_valid_i = 3'b000;
    bus.fence_req_i = 1'b1;
    #1; model_eval(); tick();
    bus.fence_req_i = 1'b0;
    bus.req_valid_i = 3'b011;
    for (int c = 1; c <= 11; c++) begin
      bus.store_ack_i = (c == 4 || c == 9);
      #1; model_eval();
      total++;
      if (c <= 10 && bus.req_ready_o !== 3'b000) begin
        bad++; $display("FAIL fence_block c%0d: got %b want 000", c, bus.req_ready_o);
      end else if (c == 11 && bus.req_ready_o !== 3'b001) begin
        bad++; $display("FAIL fence_resume: got %b want 001", bus.req_ready_o);
      end
      total++;
      if (bus.fence_done_o !== 1'(c == 10)) begin
        bad++; $display("FAIL fence_done c%0d: got %b want %b", c, bus.fence_done_o, (c == 10));
      end
      tick();
    end
    bus.store_ack_i = 1'b0;
    bus.req_valid_i = 3'b000;
  endtask

  task automatic test_ack_error();
    do_reset();
    bus.mem_req_ready_i = 1'b1;
    bus.store_ack_i = 1'b1;
    #1; model_eval(); tick();
    bus.store_ack_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1; model_eval();
      total++;
      if (bus.err_o !== 1'b1 || bus.stores_pending_o !== 3'd0) begin
        bad++; $display("FAIL err_sticky c%0d: err=%b cnt=%0d want 1/0", c, bus.err_o, bus.stores_pending_o);
      end
      tick();
    end
    bus.req_valid_i = 3'b100;
    for (int c = 0; c < 4; c++) begin
      rand_fields(); #1; model_eval(); tick();
    end
    bus.store_ack_i = 1'b1;
    #1; model_eval();
    total++;
    if (bus.req_ready_o !== 3'b100) begin
      bad++; $display("FAIL acc_ack_ready: got %b want 100", bus.req_ready_o);
    end
    tick();
    bus.store_ack_i = 1'b0;
    bus.req_valid_i = 3'b000;
    #1;
    total++;
    if (bus.stores_pending_o !== 3'd4 || bus.err_o !== 1'b1) begin
      bad++; $display("FAIL acc_ack_cnt: cnt=%0d err=%b want 4/1", bus.stores_pending_o, bus.err_o);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      bus.req_valid_i     = 3'($urandom);
      bus.req_nc_i        = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      bus.mem_req_ready_i = ($urandom_range(0, 3) != 0);
      bus.store_ack_i     = (m_cnt > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0);
      bus.fence_req_i     = ($urandom_range(0, 39) == 0);
      rand_fields();
      #1; model_eval();
      total++;
      if (bus.req_ready_o !== e_ready) begin
        bad++; $display("FAIL rnd_ready c%0d: got %b want %b", c, bus.req_ready_o, e_ready);
      end
      total++;
      if (bus.mem_req_valid_o !== m_valid) begin
        bad++; $display("FAIL rnd_valid c%0d: got %b want %b", c, bus.mem_req_valid_o, m_valid);
      end
      if (m_valid) begin
        total++;
        if (bus.mem_req_src_o !== 2'(m_src) || bus.mem_req_addr_o !== m_addr ||
            bus.mem_req_wdata_o !== m_wdata || bus.mem_req_be_o !== m_be ||
            bus.mem_req_tid_o !== m_tid || bus.mem_req_nc_o !== m_nc) begin
          bad++; $display("FAIL rnd_fields c%0d: src=%0d addr=%h be=%h tid=%0d nc=%b want %0d/%h/%h/%0d/%b",
                          c, bus.mem_req_src_o, bus.mem_req_addr_o, bus.mem_req_be_o, bus.mem_req_tid_o,
                          bus.mem_req_nc_o, m_src, m_addr, m_be, m_tid, m_nc);
        end
      end
      total++;
      if (bus.stores_pending_o !== 3'(m_cnt) || bus.err_o !== m_err ||
          bus.fence_done_o !== 1'(m_phase == 2)) begin
        bad++; $display("FAIL rnd_status c%0d: cnt=%0d err=%b done=%b want %0d/%b/%b",
                        c, bus.stores_pending_o, bus.err_o, bus.fence_done_o, m_cnt, m_err, (m_phase == 2));
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    test_reset();
    test_round_robin();
    test_store_limit();
    test_nc_load();
    test_backpressure();
    test_fence();
    test_ack_error();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wt_mem_req_arbiter.md
Name: wt_mem_req_arbiter

Overview:
- Shares the single write-through cache memory request port between three requesters: instruction fetch miss (port 0), data-cache load miss (port 1) and write-buffer store (port 2).
- Round-robin arbitration feeds a one-entry registered output stage.
- Tracks outstanding stores up to MaxOutstandingStores.
- Enforces ordering for non-idempotent loads.
- Sequences fence drains.
- Sits between the instruction cache / WT data cache and the NoC adapter.

Parameters:
- AddrWidth, 64, request address width.
- DataWidth, 64, store data width; byte-enable width is DataWidth/8.
- TidWidth, 2, transaction ID width.
- MaxOutstandingStores, 7, maximum stores issued but not yet acknowledged.
- CntWidth, $clog2(MaxOutstandingStores+1), width of the pending-store counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  3  per-requester request valid; bit0 ifetch, bit1 load, bit2 store.
- req_ready_o  out  3  per-requester accept.
- req_addr_i  in  3*AddrWidth  per-requester address; slice p holds port p.
- req_nc_i  in  3  per-requester non-idempotent region flag.
- req_tid_i  in  3*TidWidth  per-requester transaction ID.
- store_wdata_i  in  DataWidth  store data; port 2 only.
- store_be_i  in  DataWidth/8  store byte enables.
- mem_req_valid_o  out  1  output request valid.
- mem_req_ready_i  in  1  NoC adapter accept.
- mem_req_src_o  out  2  granted port index.
- mem_req_addr_o  out  AddrWidth  address of the held request.
- mem_req_wdata_o  out  DataWidth  store data of the held request.
- mem_req_be_o  out  DataWidth/8  byte enables of the held request.
- mem_req_tid_o  out  TidWidth  transaction ID of the held request.
- mem_req_nc_o  out  1  non-idempotent flag of the held request.
- store_ack_i  in  1  one-cycle pulse per store acknowledgement.
- fence_req_i  in  1  level request to drain all stores.
- fence_done_o  out  1  one-cycle pulse when the drain completes.
- stores_pending_o  out  CntWidth  outstanding store count.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset (async, rst_ni=0): all outputs 0; output register empty; round-robin pointer rr=0; counter 0; FSM in IDLE.
  - Reset mid-transaction drops the held request with no replay; upstream re-issues.
- Output stage "free" = register empty OR (mem_req_valid_o && mem_req_ready_i).
- Eligibility of port p: req_valid_i[p] AND not blocked AND FSM==IDLE.
  - Port 2 (store) blocked when cnt==MaxOutstandingStores.
  - Port 1 (load) blocked when req_nc_i[1] && (cnt!=0 OR the held request is a store).
  - Port 0 is never blocked by the counter.
- Grant: when free, pick the first eligible port scanning rr, rr+1, rr+2 (mod 3).
  - req_ready_o has at most one bit set: the granted port, only when free.
  - req_ready_o is combinational from inputs and state; no dependency on the same port's req_valid_i beyond eligibility.
- Accept (valid&&ready on port p): output register loads addr/tid/nc of port p; for p==2 it also loads wdata/be, else wdata=0, be=0.
  - src=p; mem_req_valid_o=1 next cycle (latency 1).
  - rr <= (p+1) mod 3.
  - With no accept, rr is unchanged.
- Output register holds all fields stable while mem_req_valid_o && !mem_req_ready_i.
  - Back-to-back accept on the handshake cycle gives zero-bubble throughput.
- Counter:
  - +1 on store accept into the output register.
  - −1 on store_ack_i.
  - Both in the same cycle: unchanged.
  - store_ack_i with cnt==0 and no same-cycle store accept: cnt stays 0, err_o<=1 (sticky until reset).
  - Increment beyond Max is impossible by blocking.
  - stores_pending_o = cnt.
- FSM:
  - IDLE -> DRAIN when fence_req_i=1. The transition takes effect next cycle; an accept in the same cycle still occurs.
  - DRAIN: no grants (req_ready_o=0); wait for output register empty AND cnt==0.
    - Exit DRAIN -> DONE when the condition holds. An ack arriving that cycle counts, so the condition is evaluated on next-state values.
  - DONE: fence_done_o=1 for exactly one cycle -> IDLE.
  - fence_req_i held high into IDLE re-enters DRAIN; back-to-back fences each produce one pulse.
  - fence_req_i in DRAIN or DONE is ignored.

Test Plan:
- Reset then all three valid continuously, mem_req_ready_i=1 -> mem_req_src_o sequence 0,1,2,0,1,2; first mem_req_valid_o one cycle after first accept.
- Only port 2 valid, no acks, ready=1 -> exactly 7 stores accepted, stores_pending_o=7, req_ready_o[2]=0 afterwards; one store_ack_i -> one more store accepted, count stays 7.
- cnt=3, load with req_nc_i[1]=1 and an ifetch pending -> ifetch granted, load stalled; 3 acks -> load granted the cycle after cnt reaches 0.
- mem_req_ready_i=0 for 5 cycles with a held store addr=0x8000_0010, be=0xFF -> all outputs stable, no req_ready_o asserted.
- fence_req_i with cnt=2 -> no grants; acks on cycles 4 and 9 -> fence_done_o single pulse on cycle 10, grants resume cycle 11.
- store_ack_i with cnt=0 -> err_o=1 and stays 1, count 0; store accept and ack in the same cycle at cnt=4 -> count stays 4.
